// File: rtl/sub_word_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub_word_seq
// Purpose  : Multi-byte subtraction sequencer. Drives an external 8-bit
//            subtractor macro (DIFF = A - B - CI, CO = borrow-out) one byte
//            per cycle, least-significant byte first, and assembles the
//            WORDS-byte difference, final borrow and zero flag.
// Ports    : clk, rst (async, active-high), flush (sync abort)
//            in_valid/in_ready, op_a, op_b, op_bin : operand handshake
//            sub_a, sub_b, sub_ci -> macro;  sub_diff, sub_co <- macro
//            out_valid/out_ready, result, borrow, zero : result handshake
// Revision : 1.0  initial release
// ============================================================================
module sub_word_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   op_a,
    input  logic [8*WORDS-1:0]   op_b,
    input  logic                 op_bin,
    output logic [7:0]           sub_a,
    output logic [7:0]           sub_b,
    output logic                 sub_ci,
    input  logic [7:0]           sub_diff,
    input  logic                 sub_co,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   result,
    output logic                 borrow,
    output logic                 zero
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0]    c_idle = 2'd0;
    localparam logic [1:0]    c_run  = 2'd1;
    localparam logic [1:0]    c_done = 2'd2;
    localparam logic [CW-1:0] c_last = CW'(WORDS - 1);

    logic [1:0]           r_state;
    logic [CW-1:0]        r_count;
    logic [8*WORDS-1:0]   r_a;
    logic [8*WORDS-1:0]   r_b;
    logic                 r_brw;
    logic [8*WORDS-1:0]   r_result;
    logic                 r_borrow;
    logic                 w_run;

    assign w_run = (r_state == c_run);

    // Macro path is purely combinational: the byte selected by r_count goes
    // straight out, and the macro's answer is captured on the same edge.
    always_comb begin
        sub_a  = 8'd0;
        sub_b  = 8'd0;
        sub_ci = 1'b0;
        if (w_run) begin
            sub_a  = r_a[8*r_count +: 8];
            sub_b  = r_b[8*r_count +: 8];
            sub_ci = r_brw;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_count  <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_brw    <= 1'b0;
            r_result <= '0;
            r_borrow <= 1'b0;
        end else if (flush) begin
            // Abort wins over every other action; result/borrow left as-is.
            r_state <= c_idle;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= op_a;
                        r_b     <= op_b;
                        r_brw   <= op_bin;
                        r_count <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_result[8*r_count +: 8] <= sub_diff;
                    r_brw                    <= sub_co;
                    if (r_count == c_last) begin
                        // Count stops at the last byte rather than wrapping.
                        r_borrow <= sub_co;
                        r_state  <= c_done;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign result    = r_result;
    assign borrow    = r_borrow;
    assign zero      = (r_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_sub_word_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_word_seq
// Purpose  : Self-checking bench for sub_word_seq (WORDS = 4) with a
//            behavioural 8-bit subtractor macro in the loop.
// Revision : 1.0  initial release
// ============================================================================
module tb_sub_word_seq;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        op_bin = 1'b0;
    logic [7:0]  sub_a;
    logic [7:0]  sub_b;
    logic        sub_ci;
    logic [7:0]  sub_diff;
    logic        sub_co;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        borrow;
    logic        zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External 8-bit subtractor macro: DIFF = A - B - CI, CO = borrow-out.
    logic [8:0] w_macro;
    assign w_macro  = {1'b0, sub_a} - {1'b0, sub_b} - {8'd0, sub_ci};
    assign sub_diff = w_macro[7:0];
    assign sub_co   = w_macro[8];

    sub_word_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_bin    (op_bin),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_ci    (sub_ci),
        .sub_diff  (sub_diff),
        .sub_co    (sub_co),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .borrow    (borrow),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [3:0]  eci;   // bit k = expected sub_ci in RUN cycle k
        logic [31:0] er;
        logic        eb;
        logic        ez;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".sub_a"},     32'(sub_a),     32'd0);
        check({tag, ".sub_b"},     32'(sub_b),     32'd0);
        check({tag, ".sub_ci"},    32'(sub_ci),    32'd0);
    endtask

    // Issue one operand, check every RUN cycle, and stop in DONE (after E4).
    task automatic do_op(input vec_t v, input string tag);
        @(negedge clk);
        op_a = v.a; op_b = v.b; op_bin = v.bin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Operands may change freely once accepted.
        op_a = $urandom; op_b = $urandom; op_bin = 1'b1;
        for (int k = 0; k < WORDS; k++) begin
            check({tag, ".run_in_ready"},  32'(in_ready),  32'd0);
            check({tag, ".run_out_valid"}, 32'(out_valid), 32'd0);
            check({tag, ".sub_a"},  32'(sub_a),  32'(v.a[8*k +: 8]));
            check({tag, ".sub_b"},  32'(sub_b),  32'(v.b[8*k +: 8]));
            check({tag, ".sub_ci"}, 32'(sub_ci), 32'(v.eci[k]));
            @(posedge clk); #1;
        end
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".result"},    result,         v.er);
        check({tag, ".borrow"},    32'(borrow),    32'(v.eb));
        check({tag, ".zero"},      32'(zero),      32'(v.ez));
        check({tag, ".done_sub_a"}, 32'(sub_a), 32'd0);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".rel_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".rel_in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v2;
        vec_t v3;
        vecs[0] = '{32'h12345678, 32'h00000001, 1'b0, 4'b0000, 32'h12345677, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 4'b1110, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000004, 1'b1, 4'b0001, 32'h00000000, 1'b0, 1'b1};
        vecs[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 4'b1111, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 4'b1110, 32'h00000001, 1'b0, 1'b0};

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");
        check("reset.borrow", 32'(borrow), 32'd0);
        check("reset.result", result, 32'd0);

        // Table-driven operations
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        // Backpressure with a second operand waiting
        v2 = '{32'hA0B0C0D0, 32'h0A0B0C0D, 1'b0, 4'b0000, 32'h96A5B4C3, 1'b0, 1'b0};
        do_op(vecs[1], "bp1");
        @(negedge clk);
        op_a = v2.a; op_b = v2.b; op_bin = v2.bin; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready",  32'(in_ready),  32'd0);
            check("bp.result",    result,         32'hFFFFFFFF);
            check("bp.borrow",    32'(borrow),    32'd1);
        end
        release_result("bp1");
        do_op(v2, "bp2");
        release_result("bp2");

        // Flush at count == 2
        @(negedge clk);
        op_a = 32'h11111111; op_b = 32'h01010101; op_bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;   // after E0, count 0
        @(posedge clk); #1;                   // count 1
        @(posedge clk); #1;                   // count 2
        check("flush.pre_sub_a", 32'(sub_a), 32'h11);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check_idle_outputs("flush");
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("flush.no_out_valid", 32'(out_valid), 32'd0);
        end

        // flush with in_valid in IDLE: operand not accepted
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_idle_outputs("flush_idle");

        // flush together with out_ready in DONE
        do_op(vecs[0], "flush_done");
        @(negedge clk);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b0;
        check_idle_outputs("flush_done");

        // Asynchronous reset mid-RUN, between clock edges
        @(negedge clk);
        op_a = 32'h00000000; op_b = 32'h00000001; op_bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("arst.pre_sub_ci", 32'(sub_ci), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("arst");
        check("arst.borrow", 32'(borrow), 32'd0);
        check("arst.result", result, 32'd0);
        @(negedge clk) rst = 1'b0;
        v3 = '{32'h00010000, 32'h00000001, 1'b0, 4'b0110, 32'h0000FFFF, 1'b0, 1'b0};
        do_op(v3, "after_arst");
        release_result("after_arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub_word_seq.md
# sub_word_seq

Sequencer that performs WORDS×8-bit subtraction by driving an external 8-bit DW01_sub macro one byte per cycle. The macro computes DIFF = A − B − CI with CO as borrow-out. The block sits directly upstream and downstream of that macro: it feeds the macro's A/B/CI and consumes its DIFF/CO. Operands arrive over a valid/ready handshake; the assembled difference, final borrow and zero flag leave over a second valid/ready handshake.

## Interface
- WORDS, 4, number of 8-bit bytes per operand; legal range 1..16.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous abort; returns the block to IDLE.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- op_a  input  8*WORDS  minuend.
- op_b  input  8*WORDS  subtrahend.
- op_bin  input  1  borrow-in applied to byte 0.
- sub_a  output  8  to macro A.
- sub_b  output  8  to macro B.
- sub_ci  output  1  to macro CI (borrow-in).
- sub_diff  input  8  from macro DIFF.
- sub_co  input  1  from macro CO (borrow-out).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  8*WORDS  op_a − op_b − op_bin, modulo 2^(8*WORDS).
- borrow  output  1  final borrow-out; 1 when op_a < op_b + op_bin.
- zero  output  1  1 when result == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture op_a, op_b, op_bin into registers, clear count to 0, and go to RUN.
- RUN:
  - sub_a = a_reg[8*count+7:8*count]; sub_b = b_reg[same byte]; sub_ci = brw_reg.
  - brw_reg is loaded with op_bin on acceptance.
  - Each edge: result[byte count] ← sub_diff; brw_reg ← sub_co; count ← count+1.
  - The edge that captures count == WORDS−1 moves the FSM to DONE and loads borrow ← sub_co.
- DONE:
  - out_valid = 1; result, borrow and zero are held stable.
  - On out_ready, go to IDLE.
- Outside RUN, sub_a, sub_b and sub_ci are driven to 0.
- zero is computed combinationally from the result register and is meaningful only while out_valid = 1.
- count width is max(1, clog2(WORDS)). count never exceeds WORDS−1, so there is no wrap.
- WORDS = 1: RUN lasts exactly one cycle.
- flush is sampled in every state and takes priority over everything else.
  - Next state is IDLE and out_valid drops.
  - Registered result and borrow are not cleared by flush; they are don't-care.
  - flush together with in_valid in IDLE: the operand is not accepted.
  - flush together with out_ready in DONE: next state is IDLE, same as without flush.
- Operand registers load only on the acceptance edge. op_a, op_b and op_bin may change freely after acceptance.

## Timing
- Reset values:
  - State IDLE, count 0, brw_reg 0.
  - result 0, borrow 0, so zero reads 1 but is qualified off by out_valid = 0.
  - out_valid 0, in_ready 1.
  - sub_a, sub_b and sub_ci all 0.
- rst asserted mid-RUN or in DONE takes effect immediately, without waiting for a clock edge.
- Acceptance occurs on edge E0. RUN occupies the cycles after E0..E(WORDS−1). out_valid rises after edge E(WORDS), i.e. latency of WORDS cycles.
- Minimum issue interval is WORDS+2 cycles, when out_ready is held high.
- The macro path is combinational: sub_* outputs must settle, then sub_diff/sub_co must settle, within one clk period.
- The block adds no extra register stage around the macro.
- in_ready and out_valid are never high in the same cycle.
- out_valid deasserts on the edge where out_valid && out_ready is true.

## Test plan
- Reset:
  - Stimulus: assert rst for 3 cycles, then release.
  - Required: in_ready = 1, out_valid = 0, sub_a = sub_b = 0, sub_ci = 0, borrow = 0.
- Simple subtract (WORDS = 4):
  - Stimulus: 0x12345678 − 0x00000001, bin = 0.
  - Required: sub_ci sequence 0,0,0,0; result 0x12345677, borrow 0, zero 0.
  - Required: out_valid high exactly 4 cycles after the acceptance edge.
- Full borrow chain:
  - Stimulus: 0x00000000 − 0x00000001, bin = 0.
  - Required: sub_ci sequence 0,1,1,1; result 0xFFFFFFFF, borrow 1.
- Borrow-in to zero:
  - Stimulus: 0x00000005 − 0x00000004, bin = 1.
  - Required: result 0x00000000, zero 1, borrow 0.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles in DONE, with in_valid high carrying a second operand.
  - Required: result, borrow and out_valid stable; in_ready = 0; second operand not accepted until the cycle after out_ready = 1.
  - Required: second result correct.
- Abort paths:
  - Stimulus: flush at count = 2.
  - Required: IDLE next cycle, out_valid never rises, sub_* = 0.
  - Stimulus: rst asserted mid-RUN with no clock edge.
  - Required: outputs return to reset values immediately; a fresh operation then completes correctly.
